// File: rtl/pe_ctx_sequencer_if.sv
// Handshake/config bundle between a context master (config bus side) and the PE context sequencer.
// master drives configuration and run control; slave (the sequencer) drives the PE-facing outputs.
interface pe_ctx_sequencer_if #(
    parameter int INST_W = 48,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CNT_W  = 16
);
    logic              cfg_we;
    logic [PTR_W-1:0]  cfg_addr;
    logic [INST_W-1:0] cfg_data;
    logic [PTR_W:0]    cfg_len;
    logic [CNT_W-1:0]  loop_cnt;
    logic              start;
    logic              abort;
    logic              stall;
    logic [INST_W-1:0] inst_out;
    logic              inst_valid;
    logic [PTR_W-1:0]  ctx_ptr;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        output cfg_we, cfg_addr, cfg_data, cfg_len, loop_cnt, start, abort, stall,
        input  inst_out, inst_valid, ctx_ptr, busy, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, cfg_len, loop_cnt, start, abort, stall,
        output inst_out, inst_valid, ctx_ptr, busy, done, cfg_err
    );
endinterface

// File: rtl/pe_ctx_sequencer.sv
// Per-PE context store replaying up to DEPTH instruction words cyclically for loop_cnt iterations.
// Latency: start edge -> first instruction registered out; stall freezes issue with no skip/dup, abort wins over stall.
module pe_ctx_sequencer #(
    parameter int INST_W = 48,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    pe_ctx_sequencer_if.slave   seq_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [PTR_W:0]   LEN_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   LEN_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    state_e            state_q, state_d;
    logic [INST_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    len_q, len_d;
    logic [CNT_W-1:0]  iter_q, iter_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              fin_q, fin_d;
    logic [INST_W-1:0] inst_out_q, inst_out_d;
    logic              inst_valid_q, inst_valid_d;
    logic [PTR_W-1:0]  ctx_ptr_q, ctx_ptr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic              wr_en;
    logic              start_ok;
    logic              issue;
    logic [PTR_W-1:0]  iss_ptr;
    logic [PTR_W:0]    iss_len;
    logic [CNT_W-1:0]  iss_iter;
    logic [INST_W-1:0] rd_data;

    assign wr_en    = seq_if.cfg_we && (state_q == S_IDLE);
    assign start_ok = (seq_if.cfg_len != '0) && (seq_if.cfg_len <= LEN_MAX) &&
                      (seq_if.loop_cnt != '0);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        iter_d       = iter_q;
        ptr_d        = ptr_q;
        fin_d        = fin_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = 1'b0;
        ctx_ptr_d    = ctx_ptr_q;
        cfg_err_d    = 1'b0;
        issue        = 1'b0;
        iss_ptr      = ptr_q;
        iss_len      = len_q;
        iss_iter     = iter_q;
        rd_data      = '0;

        case (state_q)
            S_IDLE: begin
                if (seq_if.start) begin
                    if (start_ok) begin
                        state_d  = S_RUN;
                        len_d    = seq_if.cfg_len;
                        iter_d   = seq_if.loop_cnt;
                        fin_d    = 1'b0;
                        issue    = 1'b1;
                        iss_ptr  = '0;
                        iss_len  = seq_if.cfg_len;
                        iss_iter = seq_if.loop_cnt;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cfg_err_d = seq_if.cfg_we;
                if (seq_if.abort) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                    fin_d   = 1'b0;
                end else if (fin_q) begin
                    // Final word is on the outputs this cycle; done follows it.
                    state_d = S_DONE;
                    fin_d   = 1'b0;
                end else if (!seq_if.stall) begin
                    issue = 1'b1;
                end
            end
            S_DONE: begin
                cfg_err_d = seq_if.cfg_we;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            // A write landing in the start cycle is forwarded to the first issue.
            if (wr_en && (seq_if.cfg_addr == iss_ptr)) begin
                rd_data = seq_if.cfg_data;
            end else begin
                rd_data = mem_q[iss_ptr];
            end
            inst_out_d   = rd_data;
            ctx_ptr_d    = iss_ptr;
            inst_valid_d = 1'b1;
            if ({1'b0, iss_ptr} == (iss_len - LEN_ONE)) begin
                ptr_d  = '0;
                iter_d = iss_iter - CNT_ONE;
                if (iss_iter == CNT_ONE) begin
                    fin_d = 1'b1;
                end
            end else begin
                ptr_d  = iss_ptr + PTR_ONE;
                iter_d = iss_iter;
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            iter_q       <= '0;
            ptr_q        <= '0;
            fin_q        <= 1'b0;
            inst_out_q   <= '0;
            inst_valid_q <= 1'b0;
            ctx_ptr_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            iter_q       <= iter_d;
            ptr_q        <= ptr_d;
            fin_q        <= fin_d;
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
            ctx_ptr_q    <= ctx_ptr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[seq_if.cfg_addr] <= seq_if.cfg_data;
        end
    end

    assign seq_if.inst_out   = inst_out_q;
    assign seq_if.inst_valid = inst_valid_q;
    assign seq_if.ctx_ptr    = ctx_ptr_q;
    assign seq_if.busy       = busy_q;
    assign seq_if.done       = done_q;
    assign seq_if.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Directed bench for pe_ctx_sequencer: scoreboard of expected issues, checked whenever inst_valid is seen.
module tb_pe_ctx_sequencer;
    localparam int INST_W = 48;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PTR_W-1:0]  ptr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   n_valid = 0;
    int   n_done = 0;
    exp_t exp_q[$];
    logic [INST_W-1:0] model [DEPTH];
    logic [INST_W-1:0] last_inst;

    pe_ctx_sequencer_if #(.INST_W(INST_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) bus ();

    pe_ctx_sequencer #(.INST_W(INST_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.inst_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("issue while nothing expected", 64'(bus.inst_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                last_inst = e.inst;
                chk("inst_out", 64'(bus.inst_out), 64'(e.inst));
                chk("ctx_ptr", 64'(bus.ctx_ptr), 64'(e.ptr));
            end
        end
        if (bus.done === 1'b1) n_done++;
    endtask

    task automatic push_run(input int len, input int cnt);
        exp_t e;
        for (int it = 0; it < cnt; it++) begin
            for (int p = 0; p < len; p++) begin
                e.inst = model[p];
                e.ptr  = PTR_W'(p);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wr(input int addr, input logic [INST_W-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = PTR_W'(addr);
        bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0;
        model[addr] = data;
        chk("write cfg_err", 64'(bus.cfg_err), 64'd0);
    endtask

    task automatic bad_start(input string tag, input int len, input int cnt);
        bus.cfg_len  = (PTR_W+1)'(len);
        bus.loop_cnt = CNT_W'(cnt);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, " cfg_err"}, 64'(bus.cfg_err), 64'd1);
        chk({tag, " busy"}, 64'(bus.busy), 64'd0);
        chk({tag, " valid"}, 64'(bus.inst_valid), 64'd0);
        tick();
        chk({tag, " cfg_err pulse"}, 64'(bus.cfg_err), 64'd0);
    endtask

    task automatic do_run(input string tag, input int len, input int cnt, input int stall_at,
                          input int stall_n, input int abort_at, input int we_at);
        int v0;
        int n;
        int done_seen;
        logic in_stall;
        v0 = n_valid;
        n = len * cnt + stall_n;
        done_seen = -1;
        push_run(len, cnt);
        bus.cfg_len  = (PTR_W+1)'(len);
        bus.loop_cnt = CNT_W'(cnt);
        bus.start    = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        chk({tag, " busy at start"}, 64'(bus.busy), 64'd1);
        chk({tag, " valid at start"}, 64'(bus.inst_valid), 64'd1);
        chk({tag, " cfg_err at start"}, 64'(bus.cfg_err), 64'd0);
        for (int c = 1; c <= n + 2 && done_seen < 0; c++) begin
            in_stall  = (c >= stall_at) && (c < stall_at + stall_n);
            bus.stall = in_stall;
            bus.abort = (c == abort_at);
            if (c == we_at) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = PTR_W'(1);
                bus.cfg_data = 48'hDEAD_BEEF_0001;
            end
            tick();
            bus.stall  = 1'b0;
            bus.abort  = 1'b0;
            bus.cfg_we = 1'b0;
            if (in_stall) begin
                chk({tag, " stall valid"}, 64'(bus.inst_valid), 64'd0);
                chk({tag, " stall hold"}, 64'(bus.inst_out), 64'(last_inst));
            end
            if (c == we_at) chk({tag, " write in run cfg_err"}, 64'(bus.cfg_err), 64'd1);
            if (c == abort_at) begin
                chk({tag, " abort valid"}, 64'(bus.inst_valid), 64'd0);
                chk({tag, " abort busy"}, 64'(bus.busy), 64'd0);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk({tag, " no done after abort"}, 64'(bus.done), 64'd0);
                end
                chk({tag, " abort leftover"}, 64'(exp_q.size()), 64'(len * cnt - c));
                exp_q.delete();
                return;
            end
            if (bus.done === 1'b1) done_seen = c;
        end
        chk({tag, " done cycle"}, 64'(done_seen), 64'(n));
        chk({tag, " busy with done"}, 64'(bus.busy), 64'd0);
        chk({tag, " valid count"}, 64'(n_valid - v0), 64'(len * cnt));
        chk({tag, " scoreboard drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        tick();
        chk({tag, " done one pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int d0;
        rst_n        = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.cfg_len  = '0;
        bus.loop_cnt = '0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.stall    = 1'b0;
        last_inst    = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        #2;
        chk("reset inst_out", 64'(bus.inst_out), 64'd0);
        chk("reset valid", 64'(bus.inst_valid), 64'd0);
        chk("reset ctx_ptr", 64'(bus.ctx_ptr), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        chk("reset cfg_err", 64'(bus.cfg_err), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        wr(0, 48'h0000_0007_21AF);
        wr(1, 48'h1000_0000_0003);
        wr(2, 48'h2000_0000_0001);
        do_run("base 3x2", 3, 2, 0, 0, 0, 0);
        do_run("stall 3x2", 3, 2, 1, 2, 0, 0);

        for (int i = 3; i < DEPTH; i++) wr(i, 48'hA5A5_0000_0000 | 48'(i));
        do_run("full 8x1", 8, 1, 0, 0, 0, 0);
        do_run("single 1x3", 1, 3, 0, 0, 0, 0);
        do_run("write in run", 3, 2, 0, 0, 0, 1);

        bad_start("loop_cnt zero", 3, 0);
        bad_start("cfg_len zero", 0, 2);
        bad_start("cfg_len over", DEPTH + 1, 2);

        d0 = n_done;
        do_run("abort 3x2", 3, 2, 0, 0, 3, 0);
        chk("abort done count", 64'(n_done - d0), 64'd0);
        do_run("replay after abort", 3, 1, 0, 0, 0, 0);

        bus.cfg_we   = 1'b1;
        bus.cfg_addr = '0;
        bus.cfg_data = 48'h3000_0000_00AA;
        model[0]     = 48'h3000_0000_00AA;
        do_run("write with start", 3, 1, 0, 0, 0, 0);

        push_run(3, 2);
        bus.cfg_len  = 4'd3;
        bus.loop_cnt = 16'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid-run reset inst_out", 64'(bus.inst_out), 64'd0);
        chk("mid-run reset valid", 64'(bus.inst_valid), 64'd0);
        chk("mid-run reset ctx_ptr", 64'(bus.ctx_ptr), 64'd0);
        chk("mid-run reset busy", 64'(bus.busy), 64'd0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_run("zeros after reset", 3, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
